// File: rtl/cpu_mul_seq_if.sv
// cpu_mul_seq_if: request/response handshake and multiplier-cell bus for cpu_mul_seq.
interface cpu_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
        output req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
    );
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
        input  req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/cpu_mul_seq.sv
// cpu_mul_seq: 32x32 multiply sequencer over a 16x16 cell; high-word ops (MULX*) exist only
// when CPU_MUL_SEQ_MULX_EN is defined, otherwise every request is a low-word MUL.
module cpu_mul_seq (
    input  logic         clk,
    input  logic         reset_n,
    cpu_mul_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE1, CAP1, CAP2, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] a, b, src1_q, src2_q, src1, src2, data_q, data_nx, lo_word;
    logic [32:0] mid_now;
    logic        en, mulx;
    assign mid_now = {1'b0, bus.cell_p2} + {1'b0, bus.cell_p3};
    assign lo_word = bus.cell_p1 + {mid_now[15:0], 16'h0};
`ifdef CPU_MUL_SEQ_MULX_EN
    logic [1:0]  op;
    logic [31:0] p1_q, hi_word;
    logic [32:0] mid_q;
    logic [63:0] u;
    assign mulx = op != 2'd0;
    assign u = {bus.cell_p1, 32'h0} + {15'h0, mid_q, 16'h0} + {32'h0, p1_q};
    // signed operand correction: a negative operand subtracts the other from the high word
    assign hi_word = u[63:32] - ((op[1] && a[31]) ? b : 32'h0) - ((op == 2'd3 && b[31]) ? a : 32'h0);
`else
    logic unused_bits;
    assign mulx = 1'b0;
    assign unused_bits = ^{bus.req_op, mid_now[32:16]};
`endif
    always_comb begin
        state_nx = state;
        data_nx  = data_q;
        en       = 1'b0;
        src1     = src1_q;
        src2     = src2_q;
        case (state)
            IDLE:   state_nx = bus.req_valid ? ISSUE1 : IDLE;
            ISSUE1: begin
                en       = 1'b1;
                src1     = a;
                src2     = b;
                state_nx = CAP1;
            end
            CAP1: begin
                en       = mulx;
                src1     = mulx ? {16'h0, a[31:16]} : src1_q;
                src2     = mulx ? {16'h0, b[31:16]} : src2_q;
                data_nx  = mulx ? data_q : lo_word;
                state_nx = mulx ? CAP2 : DONE;
            end
`ifdef CPU_MUL_SEQ_MULX_EN
            CAP2: begin
                data_nx  = hi_word;
                state_nx = DONE;
            end
`endif
            DONE:    state_nx = bus.rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a      <= 32'h0;
            b      <= 32'h0;
            src1_q <= 32'h0;
            src2_q <= 32'h0;
            data_q <= 32'h0;
`ifdef CPU_MUL_SEQ_MULX_EN
            op     <= 2'd0;
            p1_q   <= 32'h0;
            mid_q  <= 33'h0;
`endif
        end else begin
            state  <= state_nx;
            src1_q <= src1;
            src2_q <= src2;
            data_q <= data_nx;
            if (state == IDLE && bus.req_valid) begin
                a <= bus.req_a;
                b <= bus.req_b;
`ifdef CPU_MUL_SEQ_MULX_EN
                op <= bus.req_op;
`endif
            end
`ifdef CPU_MUL_SEQ_MULX_EN
            if (state == CAP1) begin
                p1_q  <= bus.cell_p1;
                mid_q <= mid_now;
            end
`endif
        end
    end
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.rsp_data  = data_q;
    assign bus.cell_en   = en;
    assign bus.cell_src1 = src1;
    assign bus.cell_src2 = src2;
endmodule

// File: tb/tb_cpu_mul_seq.sv
// tb_cpu_mul_seq: random and directed stimulus against a transaction-level product model,
// with a behavioural 16x16 cell; follows CPU_MUL_SEQ_MULX_EN like the design.
module tb_cpu_mul_seq;
`ifdef CPU_MUL_SEQ_MULX_EN
    localparam bit MX = 1'b1;
`else
    localparam bit MX = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          en_cnt = 0;
    logic [31:0] ls1 = 32'h0;
    logic [31:0] cp1 = 32'h0, cp2 = 32'h0, cp3 = 32'h0;
    logic        m_busy = 1'b0;
    int          m_n = 0, m_lat = 3;
    logic [31:0] m_res = 32'h0, m_a = 32'h0, m_b = 32'h0, m_data = 32'h0, m_src1 = 32'h0, m_src2 = 32'h0;

    cpu_mul_seq_if bus();
    cpu_mul_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.cell_p1 = cp1;
    assign bus.cell_p2 = cp2;
    assign bus.cell_p3 = cp3;

    always @(posedge clk)
        if (bus.cell_en) begin
            cp1 <= {16'h0, bus.cell_src1[15:0]} * {16'h0, bus.cell_src2[15:0]};
            cp2 <= {16'h0, bus.cell_src1[15:0]} * {16'h0, bus.cell_src2[31:16]};
            cp3 <= {16'h0, bus.cell_src1[31:16]} * {16'h0, bus.cell_src2[15:0]};
            en_cnt <= en_cnt + 1;
            ls1 <= bus.cell_src1;
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (MX && op[1]) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (MX && op == 2'd3) ? {{32{b[31]}}, b} : {32'h0, b};
        p = ea * eb;
        return (MX && op != 2'd0) ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return $urandom & 32'h0000_FFFF;
            3: return 32'hFFFF_0000 | $urandom;
            default: return $urandom;
        endcase
    endfunction

    // transaction model: cycle n after accept, response due at cycle m_lat
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_n    <= 0;
            m_data <= 32'h0;
            m_src1 <= 32'h0;
            m_src2 <= 32'h0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy <= 1'b1;
                m_n    <= 1;
                m_a    <= bus.req_a;
                m_b    <= bus.req_b;
                m_res  <= ref_result(bus.req_op, bus.req_a, bus.req_b);
                m_lat  <= (MX && bus.req_op != 2'd0) ? 4 : 3;
                m_src1 <= bus.req_a;
                m_src2 <= bus.req_b;
            end
        end else if (m_n < m_lat) begin
            m_n <= m_n + 1;
            if (m_n + 1 == m_lat) m_data <= m_res;
            if (m_n == 1 && m_lat == 4) begin
                m_src1 <= {16'h0, m_a[31:16]};
                m_src2 <= {16'h0, m_b[31:16]};
            end
        end else if (bus.rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", {31'h0, bus.req_ready}, {31'h0, !m_busy});
        chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, m_busy && m_n == m_lat});
        chk("rsp_data", bus.rsp_data, m_data);
        chk("cell_en", {31'h0, bus.cell_en}, {31'h0, m_busy && (m_n == 1 || (m_n == 2 && m_lat == 4))});
        chk("cell_src1", bus.cell_src1, m_src1);
        chk("cell_src2", bus.cell_src2, m_src2);
    end

    task automatic wait_ready();
        int g = 0;
        while (!bus.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat_exp, input int en_exp, input string nm);
        int lat, base;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.rsp_ready = 1'b1;
        wait_ready();
        @(posedge clk);
        base = en_cnt;
        #1;
        bus.req_valid = 1'b0;
        bus.req_a = $urandom;
        bus.req_b = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chk({nm, "_data"}, bus.rsp_data, exp);
        chk({nm, "_lat"}, lat, lat_exp);
        chk({nm, "_en"}, en_cnt - base, en_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.req_valid = 1'b0;
        bus.req_op = 2'd0;
        bus.req_a = 32'h0;
        bus.req_b = 32'h0;
        bus.rsp_ready = 1'b0;
        #2;
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_cell_en", {31'h0, bus.cell_en}, 32'h0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 1, "mul_basic");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MX ? 32'hFFFF_FFFE : 32'h1, MX ? 4 : 3, MX ? 2 : 1, "mulxuu_ones");
        chk("mulxuu_src_pass2", ls1, MX ? 32'h0000_FFFF : 32'hFFFF_FFFF);
        run_op(2'd3, 32'h8000_0000, 32'h8000_0000, MX ? 32'h4000_0000 : 32'h0, MX ? 4 : 3, MX ? 2 : 1, "mulxss_min");
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MX ? 32'h0 : 32'h1, MX ? 4 : 3, MX ? 2 : 1, "mulxss_m1");
        run_op(2'd2, 32'hFFFF_FFFF, 32'h2, MX ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, MX ? 4 : 3, MX ? 2 : 1, "mulxsu_neg");
        run_op(2'd2, 32'h2, 32'hFFFF_FFFF, MX ? 32'h1 : 32'hFFFF_FFFE, MX ? 4 : 3, MX ? 2 : 1, "mulxsu_pos");
        // backpressure with a competing request held on the bus
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 2'd0;
        bus.req_a = 32'd7;
        bus.req_b = 32'd9;
        bus.rsp_ready = 1'b0;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_a = 32'd5;
        bus.req_b = 32'd6;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.rsp_valid && g < 20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            chk("bp_data", bus.rsp_data, 32'h3F);
            chk("bp_ready", {31'h0, bus.req_ready}, 32'h0);
            chk("bp_en", {31'h0, bus.cell_en}, 32'h0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.rsp_valid && g < 20);
        chk("bp_next_data", bus.rsp_data, 32'd30);
        @(posedge clk);
        #1;
        // reset during CAP1 of a high-word op
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 2'd1;
        bus.req_a = 32'hFFFF_FFFF;
        bus.req_b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("mid_rst_rsp_data", bus.rsp_data, 32'h0);
        chk("mid_rst_cell_en", {31'h0, bus.cell_en}, 32'h0);
        chk("mid_rst_src1", bus.cell_src1, 32'h0);
        chk("mid_rst_src2", bus.cell_src2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        end
        run_op(2'd0, 32'd3, 32'd4, 32'h0000_000C, 3, 1, "mul_after_rst");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.req_valid = ($urandom % 3) != 0;
            bus.req_op = 2'($urandom);
            bus.req_a = pick();
            bus.req_b = pick();
            bus.rsp_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
